// File: rtl/cache_nway_lru_if.sv
// Core-side and memory-side signal bundle of the N-way LRU cache.
// The cache connects through the slave modport; the core/memory side uses master.
interface cache_nway_lru_if #(
    parameter int unsigned ADDR_W = 30
) ();
    logic              proc_read;
    logic              proc_write;
    logic              proc_flush;
    logic [ADDR_W-1:0] proc_addr;
    logic [31:0]       proc_wdata;
    logic [31:0]       proc_rdata;
    logic              proc_stall;
    logic              flush_done;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-3:0] mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_flush, proc_addr, proc_wdata,
        input  mem_rdata, mem_ready,
        output proc_rdata, proc_stall, flush_done,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_flush, proc_addr, proc_wdata,
        output mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, flush_done,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_nway_lru.sv
// N-way set-associative write-back/write-allocate cache with true-LRU replacement
// and whole-cache flush; 128-bit lines of four 32-bit words.
module cache_nway_lru #(
    parameter int unsigned WAYS   = 2,
    parameter int unsigned SETS   = 4,
    parameter int unsigned ADDR_W = 30
) (
    input  logic            clk,
    input  logic            proc_reset_n,
    cache_nway_lru_if.slave bus
);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - 2;
    localparam int unsigned AGE_W  = $clog2(WAYS);
    localparam int unsigned SCAN_W = IDX_W + AGE_W;

    typedef enum logic [2:0] {LOOKUP, WB, FILL, FLUSH, FLUSH_WB} state_e;

    state_e             state_q;
    logic               valid_q [WAYS][SETS];
    logic               dirty_q [WAYS][SETS];
    logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
    logic [127:0]       data_q  [WAYS][SETS];
    logic [AGE_W-1:0]   age_q   [WAYS][SETS];
    logic [AGE_W-1:0]   victim_q;
    logic [SCAN_W-1:0]  scan_q;
    logic               mem_read_q, mem_write_q, flush_done_q;
    logic [ADDR_W-3:0]  mem_addr_q;
    logic [127:0]       mem_wdata_q;

    logic [1:0]         off;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               req, hit, found, touch_en;
    logic [AGE_W-1:0]   hit_way, victim, touch_way;
    logic [IDX_W-1:0]   scan_set;
    logic [AGE_W-1:0]   scan_way;
    logic               scan_last;
    logic [127:0]       fill_line;

    assign off       = bus.proc_addr[1:0];
    assign idx       = bus.proc_addr[IDX_W+1:2];
    assign tag       = bus.proc_addr[ADDR_W-1:IDX_W+2];
    assign req       = bus.proc_read | bus.proc_write;
    assign scan_set  = scan_q[SCAN_W-1:AGE_W];
    assign scan_way  = scan_q[AGE_W-1:0];
    assign scan_last = (scan_q == SCAN_W'(SETS*WAYS - 1));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    // Lowest-index invalid way wins; otherwise the oldest way of the set.
    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[w][idx]) begin
                victim = AGE_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_q[w][idx] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
            end
        end
    end

    always_comb begin
        fill_line = bus.mem_rdata;
        if (bus.proc_write) fill_line[{off, 5'd0} +: 32] = bus.proc_wdata;
    end

    assign touch_en  = (state_q == LOOKUP && req && hit && !bus.proc_flush) ||
                       (state_q == FILL && bus.mem_ready);
    assign touch_way = (state_q == FILL) ? victim_q : hit_way;

    assign bus.proc_stall = req ? !(state_q == LOOKUP && hit && !bus.proc_flush)
                                : bus.proc_flush;
    assign bus.proc_rdata = hit ? data_q[hit_way][idx][{off, 5'd0} +: 32] : '0;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.flush_done = flush_done_q;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            for (int unsigned w = 0; w < WAYS; w++)
                for (int unsigned s = 0; s < SETS; s++)
                    age_q[w][s] <= AGE_W'(w);
        end else if (touch_en) begin
            for (int unsigned w = 0; w < WAYS; w++)
                if (age_q[w][idx] < age_q[touch_way][idx])
                    age_q[w][idx] <= age_q[w][idx] + AGE_W'(1);
            age_q[touch_way][idx] <= '0;
        end
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_q      <= LOOKUP;
            victim_q     <= '0;
            scan_q       <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            flush_done_q <= 1'b0;
            for (int unsigned w = 0; w < WAYS; w++) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    tag_q[w][s]   <= '0;
                    data_q[w][s]  <= '0;
                end
            end
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                LOOKUP: begin
                    if (bus.proc_flush) begin
                        scan_q  <= '0;
                        state_q <= FLUSH;
                    end else if (req && hit) begin
                        if (bus.proc_write) begin
                            data_q[hit_way][idx][{off, 5'd0} +: 32] <= bus.proc_wdata;
                            dirty_q[hit_way][idx] <= 1'b1;
                        end
                    end else if (req) begin
                        victim_q <= victim;
                        if (dirty_q[victim][idx]) begin
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_q[victim][idx], idx};
                            mem_wdata_q <= data_q[victim][idx];
                            state_q     <= WB;
                        end else begin
                            mem_read_q <= 1'b1;
                            mem_addr_q <= bus.proc_addr[ADDR_W-1:2];
                            state_q    <= FILL;
                        end
                    end
                end
                WB: begin
                    if (bus.mem_ready) begin
                        dirty_q[victim_q][idx] <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= bus.proc_addr[ADDR_W-1:2];
                        state_q     <= FILL;
                    end
                end
                FILL: begin
                    if (bus.mem_ready) begin
                        data_q[victim_q][idx]  <= fill_line;
                        tag_q[victim_q][idx]   <= tag;
                        valid_q[victim_q][idx] <= 1'b1;
                        dirty_q[victim_q][idx] <= bus.proc_write;
                        mem_read_q <= 1'b0;
                        state_q    <= LOOKUP;
                    end
                end
                FLUSH: begin
                    if (dirty_q[scan_way][scan_set]) begin
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= {tag_q[scan_way][scan_set], scan_set};
                        mem_wdata_q <= data_q[scan_way][scan_set];
                        state_q     <= FLUSH_WB;
                    end else if (scan_last) begin
                        flush_done_q <= 1'b1;
                        state_q      <= LOOKUP;
                    end else begin
                        scan_q <= scan_q + SCAN_W'(1);
                    end
                end
                FLUSH_WB: begin
                    // A written-back entry advances straight from the acknowledge.
                    if (bus.mem_ready) begin
                        dirty_q[scan_way][scan_set] <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (scan_last) begin
                            flush_done_q <= 1'b1;
                            state_q      <= LOOKUP;
                        end else begin
                            scan_q  <= scan_q + SCAN_W'(1);
                            state_q <= FLUSH;
                        end
                    end
                end
                default: state_q <= LOOKUP;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_nway_lru.sv
// Directed bench for cache_nway_lru (4 ways x 4 sets) with a fixed-latency line memory.
module tb_cache_nway_lru;
    localparam int LAT = 3;
    localparam int ENTRIES = 16;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } op_t;

    op_t          log_q[$];
    logic [127:0] mem [logic [27:0]];

    cache_nway_lru_if #(.ADDR_W(30)) bus ();
    cache_nway_lru #(.WAYS(4), .SETS(4), .ADDR_W(30)) dut (
        .clk          (clk),
        .proc_reset_n (rst_n),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] pat(input logic [27:0] a);
        return {a[23:0], 8'd3, a[23:0], 8'd2, a[23:0], 8'd1, a[23:0], 8'd0};
    endfunction

    // Acknowledges each request LAT cycles after it is raised.
    initial begin
        int cnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (rst_n && (bus.mem_read || bus.mem_write)) begin
                cnt++;
                if (cnt == LAT) begin
                    cnt = 0;
                    bus.mem_ready = 1'b1;
                    if (bus.mem_write) begin
                        mem[bus.mem_addr] = bus.mem_wdata;
                        log_q.push_back('{wr: 1'b1, addr: bus.mem_addr, data: bus.mem_wdata});
                    end else begin
                        bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : pat(bus.mem_addr);
                        log_q.push_back('{wr: 1'b0, addr: bus.mem_addr, data: '0});
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic wr, input logic [29:0] addr, input logic [31:0] wd,
                          output int cyc, output logic [31:0] rd);
        bus.proc_write = wr;
        bus.proc_read  = ~wr;
        bus.proc_addr  = addr;
        bus.proc_wdata = wd;
        cyc = 0;
        while (cyc < 200) begin
            #1;
            if (!bus.proc_stall) break;
            @(negedge clk);
            cyc++;
        end
        rd = bus.proc_rdata;
        @(posedge clk);
        @(negedge clk);
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
    endtask

    task automatic flush_run(output int n, output int nwr);
        int base;
        base = log_q.size();
        bus.proc_flush = 1'b1;
        @(negedge clk);
        bus.proc_flush = 1'b0;
        n = 1;
        while (n < 500) begin
            #1;
            if (bus.flush_done) break;
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #1 check("flush_done_pulse", 128'(bus.flush_done), 128'(0));
        nwr = log_q.size() - base;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, n, nwr, base, fd;
        logic [31:0] rd;

        rst_n = 1'b0;
        bus.proc_read = 1'b0; bus.proc_write = 1'b0; bus.proc_flush = 1'b0;
        bus.proc_addr = '0;   bus.proc_wdata = '0;
        mem[28'h04] = {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};
        #22;
        check("rst_mem_read",   128'(bus.mem_read),   128'(0));
        check("rst_mem_write",  128'(bus.mem_write),  128'(0));
        check("rst_mem_addr",   128'(bus.mem_addr),   128'(0));
        check("rst_flush_done", 128'(bus.flush_done), 128'(0));
        check("rst_stall",      128'(bus.proc_stall), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // 1: cold read miss, then same-line hit
        access(1'b0, 30'h10, '0, cyc, rd);
        check("t1_miss_cycles", 128'(cyc), 128'(1 + LAT));
        check("t1_rdata", 128'(rd), 128'(32'hD0D0_D0D0));
        check("t1_mem_ops", 128'(log_q.size()), 128'(1));
        check("t1_mem_op0", {99'(0), log_q[0].wr, log_q[0].addr}, {99'(0), 1'b0, 28'h04});
        access(1'b0, 30'h11, '0, cyc, rd);
        check("t1_hit_cycles", 128'(cyc), 128'(0));
        check("t1_hit_rdata", 128'(rd), 128'(32'hD1D1_D1D1));

        // 2: fill tags 2..4 in set 0, touch 1,2,3, miss on 5 evicts tag 4
        access(1'b0, 30'h20, '0, cyc, rd);
        check("t2_fill2_cycles", 128'(cyc), 128'(1 + LAT));
        check("t2_fill2_rdata", 128'(rd), 128'(32'h0000_0800));
        access(1'b0, 30'h30, '0, cyc, rd);
        check("t2_fill3_cycles", 128'(cyc), 128'(1 + LAT));
        access(1'b0, 30'h40, '0, cyc, rd);
        check("t2_fill4_cycles", 128'(cyc), 128'(1 + LAT));
        access(1'b0, 30'h10, '0, cyc, rd); check("t2_touch1", 128'(cyc), 128'(0));
        access(1'b0, 30'h20, '0, cyc, rd); check("t2_touch2", 128'(cyc), 128'(0));
        access(1'b0, 30'h30, '0, cyc, rd); check("t2_touch3", 128'(cyc), 128'(0));
        access(1'b0, 30'h50, '0, cyc, rd);
        check("t2_miss5_cycles", 128'(cyc), 128'(1 + LAT));
        check("t2_miss5_rdata", 128'(rd), 128'(32'h0000_1400));
        access(1'b0, 30'h10, '0, cyc, rd); check("t2_keep1", 128'(cyc), 128'(0));
        access(1'b0, 30'h20, '0, cyc, rd); check("t2_keep2", 128'(cyc), 128'(0));
        access(1'b0, 30'h30, '0, cyc, rd); check("t2_keep3", 128'(cyc), 128'(0));
        access(1'b0, 30'h40, '0, cyc, rd); check("t2_tag4_evicted", 128'(cyc), 128'(1 + LAT));

        // 3: dirty all of set 0 (tag 1 left oldest), then write-miss on tag 6
        access(1'b1, 30'h10, 32'h1111_1111, cyc, rd); check("t3_whit1", 128'(cyc), 128'(0));
        access(1'b1, 30'h21, 32'h2222_2222, cyc, rd); check("t3_whit2", 128'(cyc), 128'(0));
        access(1'b1, 30'h32, 32'h3333_3333, cyc, rd); check("t3_whit3", 128'(cyc), 128'(0));
        access(1'b1, 30'h43, 32'h4444_4444, cyc, rd); check("t3_whit4", 128'(cyc), 128'(0));
        base = log_q.size();
        access(1'b1, 30'h62, 32'hDEAD_BEEF, cyc, rd);
        check("t3_wmiss_cycles", 128'(cyc), 128'(1 + 2 * LAT));
        check("t3_mem_ops", 128'(log_q.size() - base), 128'(2));
        check("t3_wb_op", {99'(0), log_q[base].wr, log_q[base].addr}, {99'(0), 1'b1, 28'h04});
        check("t3_wb_data", log_q[base].data,
              {32'hD3D3_D3D3, 32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'h1111_1111});
        check("t3_fill_op", {99'(0), log_q[base+1].wr, log_q[base+1].addr}, {99'(0), 1'b0, 28'h18});
        access(1'b0, 30'h62, '0, cyc, rd);
        check("t3_merged_cycles", 128'(cyc), 128'(0));
        check("t3_merged_rdata", 128'(rd), 128'(32'hDEAD_BEEF));
        access(1'b0, 30'h61, '0, cyc, rd);
        check("t3_fill_word1", 128'(rd), 128'(32'h0000_1801));

        // 4: four dirty lines among 16 entries, flush writes each back in scan order
        base = log_q.size();
        flush_run(n, nwr);
        check("t4_flush_cycles", 128'(n), 128'(1 + ENTRIES + 4 * LAT));
        check("t4_flush_writes", 128'(nwr), 128'(4));
        check("t4_wb0_addr", {99'(0), log_q[base].wr, log_q[base].addr}, {99'(0), 1'b1, 28'h18});
        check("t4_wb0_data", log_q[base].data,
              {32'h0000_1803, 32'hDEAD_BEEF, 32'h0000_1801, 32'h0000_1800});
        check("t4_wb1_addr", 128'(log_q[base+1].addr), 128'(28'h08));
        check("t4_wb1_data", log_q[base+1].data,
              {32'h0000_0803, 32'h0000_0802, 32'h2222_2222, 32'h0000_0800});
        check("t4_wb2_addr", 128'(log_q[base+2].addr), 128'(28'h0C));
        check("t4_wb3_addr", 128'(log_q[base+3].addr), 128'(28'h10));
        access(1'b0, 30'h62, '0, cyc, rd);
        check("t4_still_hit", 128'(cyc), 128'(0));
        check("t4_still_data", 128'(rd), 128'(32'hDEAD_BEEF));
        flush_run(n, nwr);
        check("t4_clean_cycles", 128'(n), 128'(1 + ENTRIES));
        check("t4_clean_writes", 128'(nwr), 128'(0));

        // 6: flush and read hit together: flush first, then the read
        bus.proc_flush = 1'b1;
        bus.proc_read  = 1'b1;
        bus.proc_addr  = 30'h62;
        #1 check("t6_stall", 128'(bus.proc_stall), 128'(1));
        @(negedge clk);
        bus.proc_flush = 1'b0;
        n  = 1;
        fd = 0;
        while (n < 500) begin
            #1;
            if (bus.flush_done) fd = 1;
            if (!bus.proc_stall) break;
            @(negedge clk);
            n++;
        end
        rd = bus.proc_rdata;
        @(posedge clk);
        @(negedge clk);
        bus.proc_read = 1'b0;
        check("t6_stall_cycles", 128'(n), 128'(1 + ENTRIES));
        check("t6_flush_done", 128'(fd), 128'(1));
        check("t6_rdata", 128'(rd), 128'(32'hDEAD_BEEF));

        // 5: make tag 2 dirty and oldest, miss on tag 7, reset during its write-back
        access(1'b1, 30'h21, 32'h5555_5555, cyc, rd);
        access(1'b0, 30'h30, '0, cyc, rd);
        access(1'b0, 30'h40, '0, cyc, rd);
        access(1'b0, 30'h60, '0, cyc, rd);
        check("t5_pre_hit", 128'(cyc), 128'(0));
        base = log_q.size();
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h70;
        @(negedge clk);
        #1;
        check("t5_wb_up",   128'(bus.mem_write), 128'(1));
        check("t5_wb_addr", 128'(bus.mem_addr),  128'(28'h08));
        check("t5_no_read", 128'(bus.mem_read),  128'(0));
        #2 rst_n = 1'b0;
        #1;
        check("t5_wb_dropped", 128'(bus.mem_write), 128'(0));
        check("t5_addr_reset", 128'(bus.mem_addr),  128'(0));
        bus.proc_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 30'h60, '0, cyc, rd);
        check("t5_read_misses", 128'(cyc), 128'(1 + LAT));
        check("t5_rdata", 128'(rd), 128'(32'h0000_1800));
        check("t5_mem_ops", 128'(log_q.size() - base), 128'(1));
        check("t5_only_read", {99'(0), log_q[log_q.size()-1].wr, log_q[log_q.size()-1].addr},
              {99'(0), 1'b0, 28'h18});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
